// File: rtl/loader_pkg.sv
// Opcode set, FSM states and error codes shared between the stream loader and the decoder.
// LOADER_CHECKSUM_EN adds the CKSUM state that checks a trailing XOR byte.
package loader_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'b1111111;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_CKSUM    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_WRITE,
        ST_DONE,
`ifdef LOADER_CHECKSUM_EN
        ST_ERR,
        ST_CKSUM
`else
        ST_ERR
`endif
    } state_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, HALT: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/loader_byte_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; word_full_o pulses with the 4th byte.
// Zero latency on the pulse; the full word is visible in the register the following cycle.
module loader_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  idx_q,  idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = 2'd0;
            word_d = 32'd0;
        end else if (accept_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d                        = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = accept_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_stream_loader.sv
// Streams bytes into instruction memory as checked 32-bit words; core held until HALT is stored.
// Write 2 cycles after the 4th byte; byte_ready low outside COLLECT. LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module instr_stream_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  cpu_hold
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  done_q,  done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_q,   err_d;
    logic                  armed_q;
    logic                  asm_clear;
    logic                  accept;
    logic                  word_full;
    logic [31:0]           asm_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            cksum_q, cksum_d;
`endif

    assign accept = byte_valid && (state_q == ST_COLLECT);

    loader_byte_assembler u_asm (
        .clk         (clk),
        .rst_n       (reset_n),
        .clear_i     (asm_clear),
        .accept_i    (accept),
        .byte_i      (byte_data),
        .word_o      (asm_word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        done_d    = done_q;
        error_d   = error_q;
        err_d     = err_q;
        asm_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        cksum_d   = cksum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // armed_q masks a start that lands on the first edge after reset release
                if (start && armed_q) begin
                    state_d   = ST_COLLECT;
                    addr_d    = '0;
                    count_d   = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_d     = ERR_NONE;
                    asm_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    cksum_d   = 8'd0;
`endif
                end
            end
            ST_COLLECT: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) cksum_d = cksum_q ^ byte_data;
`endif
                if (word_full) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (is_legal_opcode(asm_word[6:0])) begin
                    state_d = ST_WRITE;
                    wdata_d = asm_word;
                end else begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                    err_d   = ERR_ILLEGAL;
                end
            end
            ST_WRITE: begin
                count_d = count_q + (ADDR_WIDTH + 1)'(1);
                if (wdata_q[6:0] == HALT) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CKSUM;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`endif
                end else if (&addr_q) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                    err_d   = ERR_OVERFLOW;
                end else begin
                    state_d = ST_COLLECT;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CKSUM: begin
                if (byte_valid) begin
                    if (byte_data == cksum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        err_d   = ERR_CKSUM;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            err_q   <= ERR_NONE;
            armed_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cksum_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            done_q  <= done_d;
            error_q <= error_d;
            err_q   <= err_d;
            armed_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == ST_COLLECT) || (state_q == ST_CKSUM);
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_CHECK) ||
                        (state_q == ST_WRITE)   || (state_q == ST_CKSUM);
`else
    assign byte_ready = (state_q == ST_COLLECT);
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_CHECK) ||
                        (state_q == ST_WRITE);
`endif
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_q;
    assign word_count = count_q;
    assign cpu_hold   = (state_q != ST_DONE);

endmodule

// File: tb/tb_instr_stream_loader.sv
// Scoreboarded bench for instr_stream_loader: a 9-bit-address instance plus a 2-bit one for overflow.
module tb_instr_stream_loader;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n, start, byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready, mem_we, busy, done, error, cpu_hold;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  err_code;
    logic [9:0]  word_count;

    logic        s_byte_ready, s_mem_we, s_busy, s_done, s_error, s_cpu_hold;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [1:0]  s_err_code;
    logic [2:0]  s_word_count;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;
    logic mon_en = 1'b0;
    logic mon_s_en = 1'b0;
    logic [8:0] exp_addr;
    logic [7:0] exp_cks;
    wr_t  q[$];
    wr_t  qs[$];

    instr_stream_loader #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .word_count(word_count), .cpu_hold(cpu_hold)
    );

    instr_stream_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(s_byte_ready), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .busy(s_busy), .done(s_done),
        .error(s_error), .err_code(s_err_code), .word_count(s_word_count), .cpu_hold(s_cpu_hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic legal(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011 || op == 7'b1101111 ||
               op == 7'b1100111 || op == 7'b1111111;
    endfunction

    always @(negedge clk) begin
        if (mon_en && mem_we) begin
            wr_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
            checks++;
            if (cyc - last_hs_cyc != 2 || byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_timing: got %0d cycles after handshake ready=%b, required 2 ready=0",
                         cyc - last_hs_cyc, byte_ready);
            end
        end
        if (mon_s_en && s_mem_we) begin
            wr_t e;
            checks++;
            if (qs.size() == 0) begin
                errors++;
                $display("FAIL s_unexpected_write: got addr=%0d, required no write", s_mem_addr);
            end else begin
                e = qs.pop_front();
                if ({7'd0, s_mem_addr} !== e.addr || s_mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL s_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             s_mem_addr, s_mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                last_hs_cyc = cyc;
                ok = 1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: got byte_ready=0 for 100 cycles, required 1");
        end
        tick();
        byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit chk_ready);
        if (legal(w[6:0])) begin
            if (mon_en)   q.push_back('{addr: exp_addr, data: w});
            if (mon_s_en) qs.push_back('{addr: exp_addr, data: w});
            exp_addr++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            exp_cks ^= b;
            send_byte(b, gap);
        end
        if (chk_ready) begin
            @(negedge clk);
            checks++;
            if (byte_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL check_ready: got ready=%b busy=%b, required ready=0 busy=1", byte_ready, busy);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        q.delete(); qs.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic do_start();
        exp_addr = '0;
        exp_cks  = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: got busy=1 after 60 cycles, required 0");
        end
        tick();
    endtask

    task automatic send_prog(input int gap, input bit chk_ready);
        send_word(32'h00500093, gap, chk_ready);
        send_word(32'h0000007F, gap, chk_ready);
`ifdef LOADER_CHECKSUM_EN
        send_byte(exp_cks, gap);
`endif
    endtask

    task automatic check_done_prog(input string tag);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || err_code !== 2'b00 || word_count !== 10'd2 ||
            cpu_hold !== 1'b0 || mem_addr !== 9'd1 || mem_wdata !== 32'h0000007F || q.size() != 0) begin
            errors++;
            $display("FAIL %s: got done=%b err=%b code=%b cnt=%0d hold=%b addr=%0d wdata=%h pend=%0d, required 1 0 00 2 0 1 0000007f 0",
                     tag, done, error, err_code, word_count, cpu_hold, mem_addr, mem_wdata, q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            err_code !== 2'b00 || word_count !== 10'd0 || mem_we !== 1'b0 ||
            byte_ready !== 1'b0 || mem_addr !== 9'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got hold=%b busy=%b done=%b err=%b code=%b cnt=%0d we=%b rdy=%b addr=%0d",
                     cpu_hold, busy, done, error, err_code, word_count, mem_we, byte_ready, mem_addr);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_at_release: got busy=%b, required 0", busy);
        end
        tick();
    endtask

    task automatic test_basic();
        mon_en = 1'b1;
        do_start();
        send_prog(0, 1'b0);
        wait_idle();
        check_done_prog("basic");
    endtask

    task automatic test_illegal();
        do_start();
        send_word(32'h00000037, 0, 1'b0);
        wait_idle();
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || err_code !== 2'b01 || done !== 1'b0 || cpu_hold !== 1'b1 ||
            word_count !== 10'd0 || mem_wdata !== 32'h0000007F) begin
            errors++;
            $display("FAIL illegal: got err=%b code=%b done=%b hold=%b cnt=%0d wdata=%h, required 1 01 0 1 0 0000007f",
                     error, err_code, done, cpu_hold, word_count, mem_wdata);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        mon_s_en = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) send_word(32'h002081B3, 0, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (s_error !== 1'b1 || s_err_code !== 2'b10 || s_word_count !== 3'd4 || s_mem_addr !== 2'd3 ||
            s_busy !== 1'b0 || s_cpu_hold !== 1'b1 || qs.size() != 0) begin
            errors++;
            $display("FAIL overflow: got err=%b code=%b cnt=%0d addr=%0d busy=%b pend=%0d, required 1 10 4 3 0 0",
                     s_error, s_err_code, s_word_count, s_mem_addr, s_busy, qs.size());
        end
        checks++;
        if (busy !== 1'b1 || word_count !== 10'd4 || q.size() != 0) begin
            errors++;
            $display("FAIL wide_no_overflow: got busy=%b cnt=%0d pend=%0d, required 1 4 0", busy, word_count, q.size());
        end
        mon_s_en = 1'b0;
    endtask

    task automatic test_throttled();
        do_reset();
        do_start();
        send_prog(1, 1'b1);
        wait_idle();
        check_done_prog("throttled");
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        do_start();
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b we=%b hold=%b, required 0 0 1", busy, mem_we, cpu_hold);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        do_start();
        send_prog(0, 1'b0);
        wait_idle();
        check_done_prog("after_mid_reset");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        do_start();
        send_word(32'h00500093, 0, 1'b0);
        send_word(32'h0000007F, 0, 1'b0);
        send_byte(exp_cks ^ 8'hFF, 0);
        wait_idle();
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || err_code !== 2'b11 || done !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL cksum_bad: got err=%b code=%b done=%b, required 1 11 0", error, err_code, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_overflow();
        test_throttled();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
